pwm_ramp_sched: RTL and testbench
=================================

# pwm_ramp_sched

Soft-start ramp scheduler for the PWM channel bank. It holds a per-channel target duty cycle and step size, loaded through a valid/ready config port. On every ramp tick it walks all channels in fixed order and moves each channel's live duty-cycle value one step toward its target. The live values drive the `duty_cycle_usec` inputs of the `pwm` instances directly, so host writes produce gradual rather than abrupt output changes.

## Interface
- `CHANNELS`, 4: number of PWM channels scheduled; at most 16.
- `CH_BITS`, 2: channel index width; must equal clog2(`CHANNELS`).
- `WIDTH`, 16: duty-cycle width, matching the `pwm` duty input.
- `TICK_DIV`, 1000: clk cycles per ramp tick; must be greater than `CHANNELS`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accept; high only in IDLE.
- `cfg_ch`  in  `CH_BITS`  channel to configure.
- `cfg_target`  in  `WIDTH`  new target duty.
- `cfg_step`  in  `WIDTH`  new step per tick; 0 means jump to target.
- `duty_flat`  out  `CHANNELS`*`WIDTH`  live duty values; channel i occupies bits [i*`WIDTH` +: `WIDTH`].
- `busy`  out  `CHANNELS`  bit i high while live duty i differs from target i.
- `done_pulse`  out  1  one-cycle strobe when a channel reaches its target.
- `done_ch`  out  `CH_BITS`  channel index for `done_pulse`.

## Operation
- **Prescaler:** free-running counter 0..`TICK_DIV`-1. `tick` is asserted while the count equals `TICK_DIV`-1, then the counter wraps to 0. The prescaler never stalls.
- **FSM states:** IDLE and SCAN, with a scan index `idx`.
  - IDLE → SCAN on `tick`, with `idx`=0.
  - SCAN updates channel `idx` on each edge and increments `idx`.
  - SCAN → IDLE after the edge that updates `idx`=`CHANNELS`-1.
- **Config port:** `cfg_ready` = (state==IDLE), combinational. On an edge with `cfg_valid`&&`cfg_ready`:
  - `target[cfg_ch]` ← `cfg_target` and `step[cfg_ch]` ← `cfg_step`.
  - `busy[cfg_ch]` ← (`cfg_target` != `duty[cfg_ch]`).
  - The live duty value is not modified; a ramp in progress continues from its current value toward the new target.
- **Update rule for channel c,** unsigned, using `WIDTH`+1-bit intermediates, no wrap:
  - If cur == tgt: no change and no strobe.
  - If step == 0: next = tgt.
  - If tgt > cur: next = min(cur+step, tgt).
  - If tgt < cur: next = (cur−tgt ≤ step) ? tgt : cur−step.
  - If next == tgt: on the same edge `busy[c]`←0, `done_pulse`←1, `done_ch`←c.
- **`done_pulse`** is cleared on every edge that does not set it. Several channels finishing in one scan produce separate strobes on consecutive cycles, in index order.
- **Simultaneous `tick` and accepted config in IDLE:** both take effect on the same edge. The scan that follows uses the new target and step.

## Timing
- **Reset values:**
  - `duty_flat`, targets, steps: all 0.
  - `busy` = 0, `done_pulse` = 0, `done_ch` = 0.
  - Prescaler = 0, state = IDLE, so `cfg_ready` = 1.
  - Asserting `rst_n` low mid-scan clears all of the above immediately.
- **Latency:** channel i's duty changes at the edge i+1 cycles after the `tick` edge.
- **Scan length:** SCAN lasts exactly `CHANNELS` cycles. With `TICK_DIV` > `CHANNELS`, a scan always ends before the next tick, so no tick is lost.
- **Config stall:** `cfg_ready` is low for exactly `CHANNELS` cycles per tick. A request held through SCAN is accepted on the first IDLE edge.
- **Registered outputs:** `duty_flat`, `busy`, `done_pulse` and `done_ch` are all registered, with no combinational path from the cfg inputs.

## Test plan
Bench parameters: `CHANNELS`=4, `TICK_DIV`=8.
- **Reset:** pulse `rst_n` low → `duty_flat`=0, `busy`=0, `done_pulse`=0, `cfg_ready`=1. Then release `rst_n` → the first `tick` arrives 8 cycles later.
- **Ramp up:** cfg ch1 target=100 step=30 → duty1 = 30, 60, 90, 100 on four successive ticks. On the 4th update edge: `done_pulse`=1, `done_ch`=1, `busy[1]` falls. Other channels unchanged.
- **Jump and ramp down:** cfg ch2 target=500 step=0 → duty2=500 at the first scan. Then cfg target=0 step=200 → 300, 100, 0, with a strobe on 0.
- **Saturation:** ch3 ramped to 0x2000, then target=0xFFFF step=0xF000 → next = 0xFFFF, not a wrapped value. Then target=0x0010 step=0xFFFF → 0x0010 in one tick.
- **Handshake:** `cfg_valid` raised on the `tick` edge+1 → `cfg_ready` low for 4 cycles and accepted on cycle 5. A request coincident with `tick` in IDLE → its target is used in that same scan.
- **Mid-scan reset and multi-done:** ch0 and ch3 finishing in one scan → strobes at scan cycles 0 and 3. Asserting `rst_n` low during scan cycle 2 → all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pwm_ramp_sched.sv
// pwm_ramp_sched: soft-start ramp scheduler for the PWM channel bank.
// Every ramp tick the channels are walked in index order, one per clock.
// Each live duty value moves one step toward its target. Targets and steps
// are loaded through a valid/ready port that is only open between scans.
module pwm_ramp_sched #(
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2,
   parameter int WIDTH    = 16,
   parameter int TICK_DIV = 1000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [CH_BITS-1:0]          cfg_ch,
   input  logic [WIDTH-1:0]            cfg_target,
   input  logic [WIDTH-1:0]            cfg_step,
   output logic [CHANNELS*WIDTH-1:0]   duty_flat,
   output logic [CHANNELS-1:0]         busy,
   output logic                        done_pulse,
   output logic [CH_BITS-1:0]          done_ch
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t               state_q, state_d;
   logic [CH_BITS-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 tick;
   logic                 scan_en;
   logic                 cfg_fire;

   logic [WIDTH-1:0]     duty_q [CHANNELS];
   logic [WIDTH-1:0]     duty_d [CHANNELS];
   logic [WIDTH-1:0]     tgt_q  [CHANNELS];
   logic [WIDTH-1:0]     tgt_d  [CHANNELS];
   logic [WIDTH-1:0]     step_q [CHANNELS];
   logic [WIDTH-1:0]     step_d [CHANNELS];
   logic [CHANNELS-1:0]  busy_q, busy_d;
   logic                 done_pulse_q, done_pulse_d;
   logic [CH_BITS-1:0]   done_ch_q, done_ch_d;

   logic [WIDTH-1:0]     cur, tgt, stp, nxt;
   logic [WIDTH:0]       sum;

   // Free-running prescaler; tick marks the last count of each period.
   always_comb begin
      tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // FSM state register plus scan index and prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: a tick starts a scan, the last channel ends it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == CH_BITS'(CHANNELS - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // FSM outputs: config port open only while idle.
   always_comb begin
      cfg_ready = (state_q == IDLE);
      scan_en   = (state_q == SCAN);
      cfg_fire  = cfg_valid && (state_q == IDLE);
   end

   // Channel update and config writes; the two never overlap since config
   // is only accepted in IDLE and updates only happen in SCAN.
   always_comb begin
      duty_d       = duty_q;
      tgt_d        = tgt_q;
      step_d       = step_q;
      busy_d       = busy_q;
      done_pulse_d = 1'b0;
      done_ch_d    = done_ch_q;

      cur = duty_q[idx_q];
      tgt = tgt_q[idx_q];
      stp = step_q[idx_q];
      // One extra bit so cur+step saturates at target instead of wrapping.
      sum = {1'b0, cur} + {1'b0, stp};
      nxt = cur;
      if (stp == '0)
         nxt = tgt;
      else if (tgt > cur)
         nxt = (sum >= {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
      else if (tgt < cur)
         nxt = ((cur - tgt) <= stp) ? tgt : cur - stp;

      if (scan_en && (cur != tgt)) begin
         duty_d[idx_q] = nxt;
         if (nxt == tgt) begin
            busy_d[idx_q] = 1'b0;
            done_pulse_d  = 1'b1;
            done_ch_d     = idx_q;
         end
      end

      if (cfg_fire) begin
         tgt_d[cfg_ch]  = cfg_target;
         step_d[cfg_ch] = cfg_step;
         busy_d[cfg_ch] = (cfg_target != duty_q[cfg_ch]);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q       <= '{default: '0};
         tgt_q        <= '{default: '0};
         step_q       <= '{default: '0};
         busy_q       <= '0;
         done_pulse_q <= 1'b0;
         done_ch_q    <= '0;
      end else begin
         duty_q       <= duty_d;
         tgt_q        <= tgt_d;
         step_q       <= step_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
         done_ch_q    <= done_ch_d;
      end
   end

   // Flatten live duty values for the pwm instances.
   always_comb begin
      duty_flat = '0;
      for (int unsigned i = 0; i < CHANNELS; i++)
         duty_flat[i*WIDTH +: WIDTH] = duty_q[i];
      busy       = busy_q;
      done_pulse = done_pulse_q;
      done_ch    = done_ch_q;
   end

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Self-checking bench for pwm_ramp_sched: directed scenarios with literal
// expectations, then random config traffic, all compared every cycle
// against a cycle-number based behavioural model.
module tb_pwm_ramp_sched;

   localparam int CH = 4;
   localparam int W  = 16;
   localparam int TD = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [W-1:0]  cfg_target;
   logic [W-1:0]  cfg_step;
   logic [CH*W-1:0] duty_flat;
   logic [CH-1:0] busy;
   logic          done_pulse;
   logic [1:0]    done_ch;

   int errors = 0;
   int checks = 0;

   pwm_ramp_sched #(.CHANNELS(CH), .CH_BITS(2), .WIDTH(W), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_target(cfg_target), .cfg_step(cfg_step),
      .duty_flat(duty_flat), .busy(busy),
      .done_pulse(done_pulse), .done_ch(done_ch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dutyof(input int i);
      return int'(duty_flat[i*W +: W]);
   endfunction

   // ---------------- behavioural model ----------------
   int m_duty [CH];
   int m_tgt  [CH];
   int m_step [CH];
   bit m_busy [CH];
   bit m_done;
   int m_done_ch;
   int ecount;          // rising edges since reset release

   // Edge number e (1-based) updates channel (e mod TD)-1 when it falls
   // in the CH edges following a tick edge (tick edges are multiples of TD).
   function automatic bit scan_edge(input int e);
      return (e > TD) && ((e % TD) >= 1) && ((e % TD) <= CH);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int e, c, cur, tg, st, nx;
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_busy[i] = 0;
         end
         m_done = 0; m_done_ch = 0; ecount = 0;
      end else begin
         e = ecount + 1;
         m_done = 0;
         if (scan_edge(e)) begin
            c = (e % TD) - 1;
            cur = m_duty[c]; tg = m_tgt[c]; st = m_step[c];
            if (cur != tg) begin
               if (st == 0)       nx = tg;
               else if (tg > cur) nx = (cur + st > tg) ? tg : cur + st;
               else               nx = (cur - tg <= st) ? tg : cur - st;
               m_duty[c] = nx;
               if (nx == tg) begin
                  m_busy[c] = 0; m_done = 1; m_done_ch = c;
               end
            end
         end else if (cfg_valid === 1'b1) begin
            m_tgt[int'(cfg_ch)]  = int'(cfg_target);
            m_step[int'(cfg_ch)] = int'(cfg_step);
            m_busy[int'(cfg_ch)] = (int'(cfg_target) != m_duty[int'(cfg_ch)]);
         end
         ecount = e;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin : compare
      logic [CH-1:0] eb;
      if (rst_n) begin
         for (int i = 0; i < CH; i++) begin
            chk($sformatf("duty%0d", i), dutyof(i), m_duty[i]);
            eb[i] = m_busy[i];
         end
         chk("busy", busy, eb);
         chk("done_pulse", done_pulse, m_done);
         chk("done_ch", done_ch, m_done_ch);
         chk("cfg_ready", cfg_ready, !scan_edge(ecount + 1));
      end
   end

   int strobe_cnt [CH];
   always @(negedge clk) begin : strobes
      if (rst_n && done_pulse) strobe_cnt[done_ch]++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_lvl(input logic lvl);
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (cfg_ready == lvl) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("wait_ready_bound", ok, 1);
   endtask

   task automatic cfg(input int ch, input int t, input int s);
      bit ok = 0;
      cfg_ch = ch[1:0]; cfg_target = t[W-1:0]; cfg_step = s[W-1:0];
      cfg_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (cfg_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("cfg_accept_bound", ok, 1);
   endtask

   task automatic scan_then_check(input string name, input int ch, input int exp);
      wait_lvl(1'b0);
      wait_lvl(1'b1);
      chk(name, dutyof(ch), exp);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int exp_up [4];
      int dp [5];
      int dc [5];
      int lows;
      exp_up = '{30, 60, 90, 100};
      for (int i = 0; i < CH; i++) strobe_cnt[i] = 0;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_target = '0; cfg_step = '0;
      repeat (2) @(negedge clk);
      chk("rst_duty", duty_flat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_ready", cfg_ready, 1);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 7) chk("first_tick_pre", cfg_ready, 1);
         if (k == 8) chk("first_tick", cfg_ready, 0);
      end

      // Ramp up ch1
      cfg(1, 100, 30);
      chk("busy1_set", busy[1], 1);
      for (int k = 0; k < 4; k++)
         scan_then_check($sformatf("ramp_up_%0d", k), 1, exp_up[k]);
      chk("busy1_clear", busy[1], 0);
      chk("ch1_strobes", strobe_cnt[1], 1);
      chk("ch0_untouched", dutyof(0), 0);

      // Jump then ramp down ch2
      cfg(2, 500, 0);
      scan_then_check("jump", 2, 500);
      cfg(2, 0, 200);
      scan_then_check("down_300", 2, 300);
      scan_then_check("down_100", 2, 100);
      scan_then_check("down_0", 2, 0);
      chk("ch2_strobes", strobe_cnt[2], 2);

      // Saturation on ch3
      cfg(3, 16'h2000, 0);
      scan_then_check("sat_base", 3, 16'h2000);
      cfg(3, 16'hFFFF, 16'hF000);
      scan_then_check("sat_up", 3, 16'hFFFF);
      cfg(3, 16'h0010, 16'hFFFF);
      scan_then_check("sat_down", 3, 16'h0010);

      // Handshake: request raised just after a tick edge
      wait_lvl(1'b1);
      wait_lvl(1'b0);
      cfg_ch = 2'd2; cfg_target = 16'd7; cfg_step = '0; cfg_valid = 1'b1;
      lows = 0;
      for (int k = 0; k < 10; k++) begin
         if (cfg_ready) break;
         lows++;
         @(negedge clk);
      end
      chk("stall_cycles", lows, 4);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      // Request coincident with tick edge
      chk("pre_tick_ready", cfg_ready, 1);
      cfg_ch = 2'd0; cfg_target = 16'd50; cfg_step = '0; cfg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("coincident_scan", cfg_ready, 0);
      @(negedge clk);
      chk("coincident_duty0", dutyof(0), 50);
      repeat (3) @(negedge clk);
      chk("held_req_duty2", dutyof(2), 7);

      // Multi-done: ch0 and ch3 finish in the same scan
      cfg(0, 80, 0);
      cfg(3, 16'h0020, 0);
      wait_lvl(1'b0);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         dp[j] = done_pulse; dc[j] = done_ch;
      end
      chk("multi_dp1", dp[1], 1);
      chk("multi_dc1", dc[1], 0);
      chk("multi_dp2", dp[2], 0);
      chk("multi_dp3", dp[3], 0);
      chk("multi_dp4", dp[4], 1);
      chk("multi_dc4", dc[4], 3);

      // Mid-scan asynchronous reset
      cfg(1, 1000, 10);
      wait_lvl(1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_duty", duty_flat, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done_pulse, 0);
      chk("mid_rst_done_ch", done_ch, 0);
      chk("mid_rst_ready", cfg_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Random config traffic
      for (int n = 0; n < 60; n++) begin
         int ch, t, s;
         repeat ($urandom_range(0, 6)) @(negedge clk);
         ch = $urandom_range(0, CH - 1);
         t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 400);
         case ($urandom_range(0, 3))
            0: s = 0;
            1: s = $urandom_range(1, 40);
            2: s = $urandom_range(1, 65535);
            default: s = $urandom_range(100, 65535);
         endcase
         cfg(ch, t, s);
      end
      repeat (120) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
